// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the ID/EX hazard controller: register-file geometry,
// flush FSM state encoding and a small saturating-increment helper.
package hazard_stall_ctrl_pkg;

    localparam int REG_W    = 4;            // register index width
    localparam int NUM_REGS = 16;           // architectural registers
    localparam int CNT_W    = 4;            // outstanding-load counter width

    typedef enum logic {
        FS_IDLE  = 1'b0,
        FS_FLUSH = 1'b1
    } flushStateT;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] satInc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// master = pipeline (drives ID/EX/MEM status), slave = hazard_stall_ctrl.
// Optional HAZ_PERF_CNT_EN adds the performance-counter signals.
interface hazard_stall_ctrl_if;
    import hazard_stall_ctrl_pkg::*;

    logic             id_valid;
    logic [REG_W-1:0] id_op1;
    logic             id_op1_use;
    logic [REG_W-1:0] id_op2;
    logic             id_op2_use;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic             ex_branch_taken;
    logic             mem_ack;
    logic [REG_W-1:0] mem_ack_rd;

    logic                stall_if;
    logic                stall_id;
    logic                flush_id;
    logic                flush_ex;
    logic [NUM_REGS-1:0] ld_pending;
    logic [CNT_W-1:0]    ld_count;

`ifdef HAZ_PERF_CNT_EN
    logic        perf_clr;
    logic [15:0] perf_raw_stalls;
    logic [15:0] perf_cap_stalls;
    logic [15:0] perf_flushes;

    modport master (
        output id_valid, id_op1, id_op1_use, id_op2, id_op2_use, id_rd,
               id_is_load, ex_branch_taken, mem_ack, mem_ack_rd, perf_clr,
        input  stall_if, stall_id, flush_id, flush_ex, ld_pending, ld_count,
               perf_raw_stalls, perf_cap_stalls, perf_flushes
    );
    modport slave (
        input  id_valid, id_op1, id_op1_use, id_op2, id_op2_use, id_rd,
               id_is_load, ex_branch_taken, mem_ack, mem_ack_rd, perf_clr,
        output stall_if, stall_id, flush_id, flush_ex, ld_pending, ld_count,
               perf_raw_stalls, perf_cap_stalls, perf_flushes
    );
`else
    modport master (
        output id_valid, id_op1, id_op1_use, id_op2, id_op2_use, id_rd,
               id_is_load, ex_branch_taken, mem_ack, mem_ack_rd,
        input  stall_if, stall_id, flush_id, flush_ex, ld_pending, ld_count
    );
    modport slave (
        input  id_valid, id_op1, id_op1_use, id_op2, id_op2_use, id_rd,
               id_is_load, ex_branch_taken, mem_ack, mem_ack_rd,
        output stall_if, stall_id, flush_id, flush_ex, ld_pending, ld_count
    );
`endif

endinterface

// File: rtl/hazard_scoreboard.sv
// Outstanding-load scoreboard: one pending bit per register plus a count of
// loads in flight. A clear is honoured only when the bit is set and the count
// is non-zero, so stray acknowledges can never underflow the counter.
// When a set and a clear hit the same register in one cycle, the set wins.
module hazard_scoreboard
    import hazard_stall_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                setEn,
    input  logic [REG_W-1:0]    setRd,
    input  logic                clrEn,
    input  logic [REG_W-1:0]    clrRd,
    input  logic [REG_W-1:0]    lookupA,
    input  logic [REG_W-1:0]    lookupB,
    output logic                pendA,
    output logic                pendB,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    count
);

    logic [NUM_REGS-1:0] pendingReg;
    logic [NUM_REGS-1:0] pendingNext;
    logic [CNT_W-1:0]    countReg;
    logic [CNT_W-1:0]    countNext;
    logic                clrOk;

    assign clrOk = clrEn & pendingReg[clrRd] & (countReg != '0);

    // Per-register next state: set has priority over clear
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : gBit
            assign pendingNext[gi] =
                (setEn && (setRd == REG_W'(gi))) ? 1'b1 :
                (clrOk && (clrRd == REG_W'(gi))) ? 1'b0 :
                pendingReg[gi];
        end
    endgenerate

    // Count moves only when exactly one of issue / valid ack happens
    always_comb begin
        countNext = countReg;
        if (setEn && !clrOk) begin
            countNext = countReg + CNT_W'(1);
        end else if (!setEn && clrOk) begin
            countNext = countReg - CNT_W'(1);
        end
    end

    // Scoreboard state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendingReg <= '0;
            countReg   <= '0;
        end else begin
            pendingReg <= pendingNext;
            countReg   <= countNext;
        end
    end

    assign pendA   = pendingReg[lookupA];
    assign pendB   = pendingReg[lookupB];
    assign pending = pendingReg;
    assign count   = countReg;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID/EX hazard controller: stalls IF/ID while a source operand waits on an
// outstanding load or the in-flight load cap is reached, and sequences the
// multi-cycle IF/ID/EX flush after a taken branch. Flush beats stall.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/flush event counters.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MAX_LD    = 2,    // 1..15
    parameter int FLUSH_CYC = 2     // 1..7
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_stall_ctrl_if.slave hz
);

    localparam logic [2:0]       FCNT_RELOAD = 3'(FLUSH_CYC - 1);
    localparam logic [CNT_W-1:0] LD_LIMIT    = CNT_W'(MAX_LD);

    flushStateT          stateReg;
    flushStateT          stateNext;
    logic [2:0]          fcntReg;
    logic [2:0]          fcntNext;

    logic                pend1;
    logic                pend2;
    logic [NUM_REGS-1:0] ldPending;
    logic [CNT_W-1:0]    ldCount;

    logic                isIdle;
    logic                rawHz;
    logic                capHz;
    logic                stallAny;
    logic                ldSet;
    logic                flushNow;

    hazard_scoreboard uScoreboard (
        .clk     (clk),
        .rst_n   (rst_n),
        .setEn   (ldSet),
        .setRd   (hz.id_rd),
        .clrEn   (hz.mem_ack),
        .clrRd   (hz.mem_ack_rd),
        .lookupA (hz.id_op1),
        .lookupB (hz.id_op2),
        .pendA   (pend1),
        .pendB   (pend2),
        .pending (ldPending),
        .count   (ldCount)
    );

    // Hazard detection straight off the registered scoreboard (no added latency)
    always_comb begin
        isIdle   = (stateReg == FS_IDLE);
        rawHz    = hz.id_valid & ((hz.id_op1_use & pend1) | (hz.id_op2_use & pend2));
        capHz    = hz.id_valid & hz.id_is_load & (ldCount == LD_LIMIT);
        stallAny = (rawHz | capHz) & isIdle & ~hz.ex_branch_taken;
        ldSet    = hz.id_valid & hz.id_is_load & ~stallAny & isIdle & ~hz.ex_branch_taken;
        flushNow = hz.ex_branch_taken | (stateReg == FS_FLUSH);
    end

    // Flush sequencing: the branch cycle itself flushes combinationally, then
    // FLUSH covers the remaining FLUSH_CYC-1 cycles; a new branch reloads.
    always_comb begin
        stateNext = stateReg;
        fcntNext  = fcntReg;
        if (stateReg == FS_IDLE) begin
            if (hz.ex_branch_taken && (FLUSH_CYC > 1)) begin
                stateNext = FS_FLUSH;
                fcntNext  = FCNT_RELOAD;
            end
        end else begin
            if (hz.ex_branch_taken) begin
                fcntNext = FCNT_RELOAD;
            end else if (fcntReg <= 3'd1) begin
                stateNext = FS_IDLE;
                fcntNext  = 3'd0;
            end else begin
                fcntNext = fcntReg - 3'd1;
            end
        end
    end

    // Flush FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= FS_IDLE;
            fcntReg  <= 3'd0;
        end else begin
            stateReg <= stateNext;
            fcntReg  <= fcntNext;
        end
    end

    assign hz.stall_if   = stallAny;
    assign hz.stall_id   = stallAny;
    assign hz.flush_id   = flushNow;
    assign hz.flush_ex   = flushNow;
    assign hz.ld_pending = ldPending;
    assign hz.ld_count   = ldCount;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] perfRawReg;
    logic [15:0] perfCapReg;
    logic [15:0] perfFlushReg;

    // Saturating event counters; perf_clr zeroes all three on the next edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perfRawReg   <= '0;
            perfCapReg   <= '0;
            perfFlushReg <= '0;
        end else if (hz.perf_clr) begin
            perfRawReg   <= '0;
            perfCapReg   <= '0;
            perfFlushReg <= '0;
        end else begin
            if (stallAny && rawHz)           perfRawReg   <= satInc16(perfRawReg);
            if (stallAny && capHz && !rawHz) perfCapReg   <= satInc16(perfCapReg);
            if (flushNow)                    perfFlushReg <= satInc16(perfFlushReg);
        end
    end

    assign hz.perf_raw_stalls = perfRawReg;
    assign hz.perf_cap_stalls = perfCapReg;
    assign hz.perf_flushes    = perfFlushReg;
`endif

endmodule
